// File: rtl/micro_ucr_nonce_ctrl_if.sv
// Host-side request/result bundle of the micro-UCR nonce-search sequencer.
// The host drives the master modport and the sequencer takes the slave modport.
interface micro_ucr_nonce_ctrl_if;
  logic        start;
  logic        abort;
  logic [95:0] header;
  logic [31:0] nonce_start;
  logic [31:0] nonce_last;
  logic [15:0] target;
  logic        busy;
  logic        done;
  logic        found;
  logic        timeout_err;
  logic [31:0] nonce_found;
  logic [23:0] hash_found;

  modport master (
    output start, abort, header, nonce_start, nonce_last, target,
    input  busy, done, found, timeout_err, nonce_found, hash_found
  );

  modport slave (
    input  start, abort, header, nonce_start, nonce_last, target,
    output busy, done, found, timeout_err, nonce_found, hash_found
  );
endinterface

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce-search sequencer: steps one hash core through a nonce range and
// reports the first nonce whose hash meets the difficulty target.
module micro_ucr_nonce_ctrl #(
  parameter int WDOG = 40
) (
  input  logic                         clk,
  input  logic                         reset_L,
  micro_ucr_nonce_ctrl_if.slave        host,
  output logic                         core_reset_L,
  output logic                         core_fin,
  output logic [127:0]                 core_bloque,
  input  logic [5:0]                   core_count,
  input  logic [23:0]                  core_H
);

  localparam int WDW = (WDOG > 1) ? $clog2(WDOG) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [95:0] hdr_r;
  logic [31:0] nonce_r;
  logic [31:0] last_r;
  logic [15:0] target_r;
  logic [WDW-1:0] wd_r;
  logic        busy_r;
  logic        done_r;
  logic        found_r;
  logic        timeout_r;
  logic [31:0] nonce_found_r;
  logic [23:0] hash_found_r;
  logic        core_reset_L_r;
  logic        core_fin_r;
  logic        hit_s;
  logic        pass_end_s;
  logic        wd_expired_s;

  // The core wraps its counter into 0 as it adds into H, so count 34 marks the end of a pass.
  assign pass_end_s   = (core_count == 6'd34);
  assign wd_expired_s = (wd_r == WDW'(WDOG - 1));
  assign hit_s        = (core_H[23:8] <= target_r);

  assign core_bloque      = {hdr_r, nonce_r};
  assign core_reset_L     = core_reset_L_r;
  assign core_fin         = core_fin_r;
  assign host.busy        = busy_r;
  assign host.done        = done_r;
  assign host.found       = found_r;
  assign host.timeout_err = timeout_r;
  assign host.nonce_found = nonce_found_r;
  assign host.hash_found  = hash_found_r;

  // Search sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r        <= IDLE;
      hdr_r          <= 96'd0;
      nonce_r        <= 32'd0;
      last_r         <= 32'd0;
      target_r       <= 16'd0;
      wd_r           <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      found_r        <= 1'b0;
      timeout_r      <= 1'b0;
      nonce_found_r  <= 32'd0;
      hash_found_r   <= 24'd0;
      core_reset_L_r <= 1'b0;
      core_fin_r     <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          wd_r           <= '0;
          busy_r         <= 1'b0;
          core_reset_L_r <= 1'b0;
          core_fin_r     <= 1'b1;
          if (host.start && !host.abort) begin
            hdr_r          <= host.header;
            nonce_r        <= host.nonce_start;
            last_r         <= host.nonce_last;
            target_r       <= host.target;
            found_r        <= 1'b0;
            timeout_r      <= 1'b0;
            busy_r         <= 1'b1;
            core_reset_L_r <= 1'b1;
            core_fin_r     <= 1'b0;
            state_r        <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end

        RUN: begin
          if (host.abort) begin
            wd_r           <= '0;
            busy_r         <= 1'b0;
            core_reset_L_r <= 1'b0;
            core_fin_r     <= 1'b1;
            state_r        <= IDLE;
          end else if (pass_end_s) begin
            wd_r    <= '0;
            state_r <= CHECK;
          end else if (wd_expired_s) begin
            wd_r           <= '0;
            timeout_r      <= 1'b1;
            done_r         <= 1'b1;
            busy_r         <= 1'b0;
            core_reset_L_r <= 1'b0;
            core_fin_r     <= 1'b1;
            state_r        <= DONE;
          end else begin
            wd_r    <= wd_r + WDW'(1'b1);
            state_r <= RUN;
          end
        end

        CHECK: begin
          if (host.abort) begin
            busy_r         <= 1'b0;
            core_reset_L_r <= 1'b0;
            core_fin_r     <= 1'b1;
            state_r        <= IDLE;
          end else if (hit_s || (nonce_r == last_r)) begin
            // A hit on the last nonce still counts as found.
            if (hit_s) begin
              found_r       <= 1'b1;
              nonce_found_r <= nonce_r;
              hash_found_r  <= core_H;
            end else begin
              found_r <= 1'b0;
            end
            done_r         <= 1'b1;
            busy_r         <= 1'b0;
            core_reset_L_r <= 1'b0;
            core_fin_r     <= 1'b1;
            state_r        <= DONE;
          end else begin
            nonce_r <= nonce_r + 32'd1;
            state_r <= RUN;
          end
        end

        DONE: begin
          busy_r         <= 1'b0;
          core_reset_L_r <= 1'b0;
          core_fin_r     <= 1'b1;
          state_r        <= IDLE;
        end

        default: begin
          wd_r           <= '0;
          busy_r         <= 1'b0;
          core_reset_L_r <= 1'b0;
          core_fin_r     <= 1'b1;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_ucr_nonce_ctrl.sv
// Directed bench for micro_ucr_nonce_ctrl with a behavioural 35-cycle hash-core model.
module tb_micro_ucr_nonce_ctrl;

  localparam logic [95:0] HDR = 96'hC35A_0000_1111_2222_0000_0010;

  logic         clk;
  logic         reset_L;
  logic         core_reset_L;
  logic         core_fin;
  logic [127:0] core_bloque;
  logic [5:0]   core_count;
  logic [23:0]  core_H;
  logic [127:0] blk_l;
  logic         stall;
  int           checks;
  int           errors;
  int           cyc;
  int           pulses;

  micro_ucr_nonce_ctrl_if host_if ();

  micro_ucr_nonce_ctrl #(.WDOG(40)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .host         (host_if),
    .core_reset_L (core_reset_L),
    .core_fin     (core_fin),
    .core_bloque  (core_bloque),
    .core_count   (core_count),
    .core_H       (core_H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy hash: H[23:8] = nonce[15:0] ^ header[15:0], H[7:0] = nonce[23:16] ^ header[95:88].
  function automatic logic [23:0] toy_hash(input logic [127:0] b);
    return {b[15:0] ^ b[47:32], b[23:16] ^ b[127:120]};
  endfunction

  // Core model: counts 0..34, loads the block at count 1, publishes H as it wraps.
  always_ff @(posedge clk or negedge core_reset_L) begin
    if (!core_reset_L) begin
      core_count <= 6'd0;
      core_H     <= 24'd0;
      blk_l      <= 128'd0;
    end else if (stall && core_count == 6'd10) begin
      core_count <= core_count;
    end else if (core_count == 6'd34) begin
      core_count <= 6'd0;
      core_H     <= toy_hash(blk_l);
    end else begin
      core_count <= core_count + 6'd1;
      if (core_count == 6'd1) blk_l <= core_bloque;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the sample point of cycle 1.
  task automatic do_start(input logic [31:0] ns, input logic [31:0] nl, input logic [15:0] tgt);
    @(negedge clk);
    host_if.header      = HDR;
    host_if.nonce_start = ns;
    host_if.nonce_last  = nl;
    host_if.target      = tgt;
    host_if.start       = 1'b1;
    @(posedge clk);
    #1;
    host_if.start = 1'b0;
  endtask

  // Returns the cycle number of the done pulse, or -1 if the budget runs out.
  task automatic wait_done(input int budget, output int c);
    int n;
    n = 1;
    c = -1;
    while (n <= budget) begin
      if (host_if.done) begin
        c = n;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stall  = 1'b0;
    host_if.start       = 1'b0;
    host_if.abort       = 1'b0;
    host_if.header      = 96'd0;
    host_if.nonce_start = 32'd0;
    host_if.nonce_last  = 32'd0;
    host_if.target      = 16'd0;
    reset_L = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     128'(host_if.busy), 128'd0);
    check("rst_done",     128'(host_if.done), 128'd0);
    check("rst_found",    128'(host_if.found), 128'd0);
    check("rst_timeout",  128'(host_if.timeout_err), 128'd0);
    check("rst_bloque",   core_bloque, 128'd0);
    check("rst_core_rst", 128'(core_reset_L), 128'd0);
    check("rst_core_fin", 128'(core_fin), 128'd1);
    reset_L = 1'b1;
    repeat (2) @(posedge clk);

    // Single nonce, always-hit target.
    do_start(32'd5, 32'd5, 16'hFFFF);
    check("t1_busy_c1",     128'(host_if.busy), 128'd1);
    check("t1_core_rst_c1", 128'(core_reset_L), 128'd1);
    check("t1_core_fin_c1", 128'(core_fin), 128'd0);
    check("t1_bloque_c1",   core_bloque, {HDR, 32'd5});
    wait_done(200, cyc);
    check("t1_done_cyc",  128'(cyc), 128'd37);
    check("t1_found",     128'(host_if.found), 128'd1);
    check("t1_nonce",     128'(host_if.nonce_found), 128'd5);
    check("t1_hash",      128'(host_if.hash_found), 128'h0015C3);
    check("t1_busy_done", 128'(host_if.busy), 128'd0);
    check("t1_core_rst",  128'(core_reset_L), 128'd0);
    @(posedge clk);
    #1;
    check("t1_done_1cyc", 128'(host_if.done), 128'd0);
    check("t1_found_hold", 128'(host_if.found), 128'd1);
    repeat (2) @(posedge clk);

    // Four misses, range exhausted.
    do_start(32'd0, 32'd3, 16'h0000);
    wait_done(200, cyc);
    check("t2_done_cyc", 128'(cyc), 128'd142);
    check("t2_found",    128'(host_if.found), 128'd0);
    check("t2_last",     128'(core_bloque[31:0]), 128'd3);
    repeat (2) @(posedge clk);

    // Wrap-around range, first hit at nonce 0.
    do_start(32'hFFFF_FFFE, 32'h0000_0001, 16'h0010);
    wait_done(200, cyc);
    check("t3_done_cyc", 128'(cyc), 128'd107);
    check("t3_found",    128'(host_if.found), 128'd1);
    check("t3_nonce",    128'(host_if.nonce_found), 128'd0);
    check("t3_hash",     128'(host_if.hash_found), 128'h0010C3);
    repeat (2) @(posedge clk);

    // Abort in cycle 20.
    do_start(32'd5, 32'd5, 16'hFFFF);
    repeat (19) @(posedge clk);
    #1;
    host_if.abort = 1'b1;
    @(posedge clk);
    #1;
    host_if.abort = 1'b0;
    check("t4_busy",     128'(host_if.busy), 128'd0);
    check("t4_core_rst", 128'(core_reset_L), 128'd0);
    check("t4_core_fin", 128'(core_fin), 128'd1);
    check("t4_found",    128'(host_if.found), 128'd0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (host_if.done) pulses++;
      @(posedge clk);
      #1;
    end
    check("t4_no_done", 128'(pulses), 128'd0);
    do_start(32'd5, 32'd5, 16'hFFFF);
    wait_done(200, cyc);
    check("t4_restart_cyc",   128'(cyc), 128'd37);
    check("t4_restart_found", 128'(host_if.found), 128'd1);
    repeat (2) @(posedge clk);

    // Stalled core trips the watchdog.
    stall = 1'b1;
    do_start(32'd0, 32'd3, 16'h0000);
    wait_done(200, cyc);
    check("t5_done_cyc", 128'(cyc), 128'd41);
    check("t5_timeout",  128'(host_if.timeout_err), 128'd1);
    check("t5_found",    128'(host_if.found), 128'd0);
    stall = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-run, then start+abort in IDLE.
    do_start(32'd9, 32'd20, 16'h0000);
    check("t6_timeout_clr", 128'(host_if.timeout_err), 128'd0);
    repeat (14) @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    check("t6_busy",     128'(host_if.busy), 128'd0);
    check("t6_bloque",   core_bloque, 128'd0);
    check("t6_nfound",   128'(host_if.nonce_found), 128'd0);
    check("t6_hfound",   128'(host_if.hash_found), 128'd0);
    check("t6_core_rst", 128'(core_reset_L), 128'd0);
    check("t6_core_fin", 128'(core_fin), 128'd1);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    @(negedge clk);
    host_if.start = 1'b1;
    host_if.abort = 1'b1;
    @(posedge clk);
    #1;
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    check("t7_busy",     128'(host_if.busy), 128'd0);
    check("t7_core_rst", 128'(core_reset_L), 128'd0);
    @(posedge clk);
    #1;
    check("t7_still_idle", 128'(host_if.busy), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
